view_ctrl: RTL and testbench
============================

# view_ctrl

Viewport and cursor controller that sits directly upstream of the VGA scan-out stage. It turns raw push-button inputs into the `shift_x`, `shift_y`, `scroll`, `setting_status` and `setting_pos` values that the scan-out stage consumes. It debounces the buttons, applies pan, zoom and cursor moves only at frame boundaries so a frame never tears, and clamps the viewport to the cell grid. It also issues cell-toggle requests to the cell-state store over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 12: scan counter width; `setting_pos` is 2*WIDTH bits.
- `HSIZE`, 800: visible width in pixels.
- `VSIZE`, 600: visible height in pixels.
- `P_PARAM_N`, 100: grid columns.
- `P_PARAM_M`, 75: grid rows.
- `POS_OFFSET`, 2: constant added to every cell address, matching the scan-out address encoding.
- `SCROLL_MIN`, 2: minimum zoom (log2 of pixels per cell).
- `SCROLL_MAX`, 5: maximum zoom.
- `SCROLL_RST`, 4: zoom value after reset.
- `DEBOUNCE`, 16: number of consecutive stable cycles required before a level change is accepted.
- `REPEAT_FRAMES`, 8: autorepeat period, used only with the macro.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw, asynchronous direction buttons.
- `btn_zoom_in`, `btn_zoom_out` in 1 each: raw zoom buttons.
- `btn_select` in 1: raw; toggles edit mode.
- `btn_toggle` in 1: raw; flips the cell under the cursor.
- `shift_x`, `shift_y` out 16: viewport origin, in cells.
- `scroll` out 4: current zoom.
- `setting_status` out 1: 1 while in edit mode.
- `setting_pos` out 2*WIDTH: cursor address.
- `toggle_valid` out 1: toggle request pending.
- `toggle_pos` out 2*WIDTH: address to flip.
- `toggle_ready` in 1: the cell store accepts the request.

## Operation
- **Input conditioning.** Each button passes through a 2-flop synchroniser, then a per-button debounce counter. The debounced level changes only after `DEBOUNCE` consecutive cycles that disagree with it. A rising edge of the debounced level sets a sticky press bit.
- **Frame-boundary consumption.** Press bits are consumed at `frame_start` and cleared in that same cycle. Several presses of one button within a frame collapse into one.
- **States.**
  - BROWSE: direction presses pan the viewport.
  - EDIT: direction presses move the cursor.
  - TOGGLE_WAIT: a request is outstanding.
- **Transitions.**
  - BROWSE -> EDIT: select press.
  - EDIT -> BROWSE: select press.
  - EDIT -> TOGGLE_WAIT: toggle press. `toggle_pos` is loaded with `setting_pos` and `toggle_valid` is raised.
  - TOGGLE_WAIT -> EDIT: the cycle where `toggle_valid && toggle_ready`.
  - In TOGGLE_WAIT, select and toggle presses are discarded; direction and zoom presses still apply.
  - A toggle press in BROWSE is discarded.
- **Update order at `frame_start`.**
  1. Zoom: `scroll` ±1, saturating at `SCROLL_MIN`/`SCROLL_MAX`. Zoom-in and zoom-out in the same frame cancel.
  2. Moves of ±1 cell. Opposing presses in the same frame cancel.
  3. Clamp, using the new `scroll`.
- **Clamp arithmetic.**
  - Compute in 17 bits: view_w = `HSIZE` >> `scroll`, view_h = `VSIZE` >> `scroll`.
  - max_x = `P_PARAM_N` - view_w if positive, else 0. max_y uses `P_PARAM_M` and view_h in the same way.
  - Shifts saturate to [0, max]; a decrement at 0 stays 0.
  - The cursor is clamped to [0, `P_PARAM_N`-1] × [0, `P_PARAM_M`-1].
  - In EDIT, if the cursor lies outside the view window, the matching shift moves by the minimum amount that brings it inside, then is re-clamped.
- **Cursor address.** `setting_pos` = cursor_y*`P_PARAM_N` + cursor_x + `POS_OFFSET`. It is driven in every state.
- **Handshake.** While `toggle_valid` is high, `toggle_pos` is held stable. `toggle_valid` deasserts in the cycle after acceptance.

## Timing
- **Reset values.**
  - `shift_x` = `shift_y` = 0.
  - `scroll` = `SCROLL_RST`.
  - `setting_status` = 0.
  - Cursor (0,0), so `setting_pos` = `POS_OFFSET`.
  - `toggle_valid` = 0 and `toggle_pos` = 0.
  - State BROWSE; all press bits, debounce counters and debounced levels cleared.
- **Reset mid-request.** Reset during TOGGLE_WAIT drops the request.
- **Press latency.** The press bit sets `DEBOUNCE`+3 cycles after a clean edge.
- **Output update.** All viewport, cursor and mode outputs change only in the cycle after `frame_start`, and never at any other time.
- **Press on the boundary.** A press bit set in the same cycle as `frame_start` is held until the next frame.
- **Toggle timing.** `toggle_valid` rises in the cycle after the consuming `frame_start`. With `toggle_ready` held high, `toggle_valid` is high for exactly 1 cycle.

## Configuration
- **With `VIEW_CTRL_AUTOREPEAT_EN` defined:** a direction button held debounced-high generates a repeat press every `REPEAT_FRAMES` frame starts, beginning `REPEAT_FRAMES` frames after the initial press. The repeat counter clears on release.
- **Without it:** exactly one move per debounced rising edge; `REPEAT_FRAMES` is unused.

## Test plan
- **Reset.** Assert reset for 1 cycle -> `shift_x`=0, `shift_y`=0, `scroll`=4, `setting_status`=0, `setting_pos`=2, `toggle_valid`=0.
- **Debounce.** Bounce `btn_right` for 10 cycles, then hold it high for 20 cycles, then pulse `frame_start` -> `shift_x`=1 exactly once. A 15-cycle glitch causes no move.
- **Clamp.** At `scroll`=4 with `shift_x`=50, press right -> stays 50. Then press zoom-in -> `scroll`=5 and `shift_x` stays 50 (max_x=75). Then press zoom-out twice -> `scroll`=3 and `shift_x`=0 (view_w=100, max_x=0).
- **Edit and follow.** Select, then right ×50 at `scroll`=4 from shift 0 -> cursor_x=50, `shift_x`=1, `setting_pos`=52.
- **Handshake.** In EDIT at cursor (3,2), press toggle with `toggle_ready`=0 for 5 cycles -> `toggle_valid` is held with `toggle_pos`=205. Select pressed meanwhile is ignored. Raising ready for 1 cycle -> `toggle_valid` drops the next cycle and the state is EDIT.
- **Simultaneous inputs.** Up+down and zoom-in+zoom-out pressed in the same frame -> no change. Reset asserted during TOGGLE_WAIT -> `toggle_valid`=0 and state BROWSE.

Source files
------------

// File: rtl/view_ctrl.sv
// view_ctrl: debounced buttons -> pan/zoom/cursor applied one cycle after frame_start; press latency DEBOUNCE+3.
// toggle_valid/toggle_pos held until toggle_ready; VIEW_CTRL_AUTOREPEAT_EN adds direction autorepeat.
module view_ctrl #(
  parameter int WIDTH         = 12,
  parameter int HSIZE         = 800,
  parameter int VSIZE         = 600,
  parameter int P_PARAM_N     = 100,
  parameter int P_PARAM_M     = 75,
  parameter int POS_OFFSET    = 2,
  parameter int SCROLL_MIN    = 2,
  parameter int SCROLL_MAX    = 5,
  parameter int SCROLL_RST    = 4,
  parameter int DEBOUNCE      = 16,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_zoom_in,
  input  logic               btn_zoom_out,
  input  logic               btn_select,
  input  logic               btn_toggle,
  output logic [15:0]        shift_x,
  output logic [15:0]        shift_y,
  output logic [3:0]         scroll,
  output logic               setting_status,
  output logic [2*WIDTH-1:0] setting_pos,
  output logic               toggle_valid,
  output logic [2*WIDTH-1:0] toggle_pos,
  input  logic               toggle_ready
);
  localparam int NB = 8;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int PW = 2 * WIDTH;
  localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_ZI = 4, B_ZO = 5, B_SEL = 6, B_TOG = 7;

  typedef enum logic [1:0] {BROWSE, EDIT, TOGGLE_WAIT} state_t;

  logic [NB-1:0] raw, sync1_q, sync2_q, lvl_q, lvl_d, lvl_dly_q, press_q, press_d, rep_fire, take;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  assign raw = {btn_toggle, btn_select, btn_zoom_out, btn_zoom_in,
                btn_right, btn_left, btn_down, btn_up};

  // A level flips only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE - 1)) lvl_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Presses landing on frame_start survive into the next frame.
  assign take    = frame_start ? press_q : '0;
  assign press_d = (lvl_q & ~lvl_dly_q) | rep_fire | (frame_start ? '0 : press_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= press_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef VIEW_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_q [4];
  logic [RW-1:0] rep_d [4];

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 4; i++) begin
      rep_d[i] = rep_q[i];
      if (!lvl_q[i]) begin
        rep_d[i] = '0;
      end else if (frame_start) begin
        if (rep_q[i] == RW'(REPEAT_FRAMES - 1)) begin
          rep_fire[i] = 1'b1;
          rep_d[i]    = '0;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 4; i++) rep_q[i] <= '0;
    else       for (int i = 0; i < 4; i++) rep_q[i] <= rep_d[i];
  end
`else
  assign rep_fire = (REPEAT_FRAMES < 0) ? '1 : '0;
`endif

  function automatic logic [16:0] step1(input logic [16:0] v, input logic inc, input logic dec);
    if (inc && !dec) return v + 17'd1;
    if (dec && !inc && v != '0) return v - 17'd1;
    return v;
  endfunction

  function automatic logic [16:0] cap(input logic [16:0] v, input logic [16:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Minimal shift that puts cursor c inside [s, s+w), then re-clamped.
  function automatic logic [16:0] follow(input logic [16:0] s, input logic [16:0] c,
                                         input logic [16:0] w, input logic [16:0] mx);
    logic [16:0] r;
    r = s;
    if (c < s) r = c;
    else if (w != '0 && c >= s + w) r = c - w + 17'd1;
    return cap(r, mx);
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        scroll_q, scroll_d;
  logic [15:0]       shx_q, shx_d, shy_q, shy_d, cx_q, cx_d, cy_q, cy_d;
  logic              setting_q, setting_d, tv_q, tv_d, edit_m;
  logic [PW-1:0]     tp_q, tp_d, pos_q, pos_d;
  logic [16:0]       view_w, view_h, max_x, max_y, sx, sy, cx, cy;

  always_comb begin
    state_d = state_q;  scroll_d = scroll_q;  setting_d = setting_q;
    shx_d = shx_q;  shy_d = shy_q;  cx_d = cx_q;  cy_d = cy_q;
    tv_d = tv_q;  tp_d = tp_q;
    view_w = '0;  view_h = '0;  max_x = '0;  max_y = '0;
    sx = {1'b0, shx_q};  sy = {1'b0, shy_q};  cx = {1'b0, cx_q};  cy = {1'b0, cy_q};
    edit_m = (state_q != BROWSE);

    if (tv_q && toggle_ready) begin
      tv_d = 1'b0;
      if (state_q == TOGGLE_WAIT) state_d = EDIT;
    end

    if (frame_start) begin
      if (take[B_ZI] && !take[B_ZO] && scroll_q < 4'(SCROLL_MAX)) scroll_d = scroll_q + 4'd1;
      if (take[B_ZO] && !take[B_ZI] && scroll_q > 4'(SCROLL_MIN)) scroll_d = scroll_q - 4'd1;

      view_w = 17'(HSIZE) >> scroll_d;
      view_h = 17'(VSIZE) >> scroll_d;
      max_x  = (17'(P_PARAM_N) > view_w) ? 17'(P_PARAM_N) - view_w : '0;
      max_y  = (17'(P_PARAM_M) > view_h) ? 17'(P_PARAM_M) - view_h : '0;

      if (edit_m) begin
        cx = cap(step1(cx, take[B_RT], take[B_LT]), 17'(P_PARAM_N - 1));
        cy = cap(step1(cy, take[B_DN], take[B_UP]), 17'(P_PARAM_M - 1));
        sx = follow(cap(sx, max_x), cx, view_w, max_x);
        sy = follow(cap(sy, max_y), cy, view_h, max_y);
      end else begin
        sx = cap(step1(sx, take[B_RT], take[B_LT]), max_x);
        sy = cap(step1(sy, take[B_DN], take[B_UP]), max_y);
      end
      shx_d = sx[15:0];  shy_d = sy[15:0];  cx_d = cx[15:0];  cy_d = cy[15:0];

      case (state_q)
        BROWSE: if (take[B_SEL]) begin
          state_d   = EDIT;
          setting_d = 1'b1;
        end
        EDIT: if (take[B_SEL]) begin
          state_d   = BROWSE;
          setting_d = 1'b0;
        end else if (take[B_TOG]) begin
          state_d = TOGGLE_WAIT;
          tv_d    = 1'b1;
          tp_d    = pos_q;
        end
        default: ;
      endcase
    end

    pos_d = PW'(cy_d) * PW'(P_PARAM_N) + PW'(cx_d) + PW'(POS_OFFSET);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BROWSE;
      scroll_q  <= 4'(SCROLL_RST);
      setting_q <= 1'b0;
      shx_q     <= '0;
      shy_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      tv_q      <= 1'b0;
      tp_q      <= '0;
      pos_q     <= PW'(POS_OFFSET);
    end else begin
      state_q   <= state_d;
      scroll_q  <= scroll_d;
      setting_q <= setting_d;
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      tv_q      <= tv_d;
      tp_q      <= tp_d;
      pos_q     <= pos_d;
    end
  end

  assign shift_x        = shx_q;
  assign shift_y        = shy_q;
  assign scroll         = scroll_q;
  assign setting_status = setting_q;
  assign setting_pos    = pos_q;
  assign toggle_valid   = tv_q;
  assign toggle_pos     = tp_q;
endmodule

// File: tb/tb_view_ctrl.sv
// Directed bench for view_ctrl: reset, debounce, clamp, edit-follow, handshake, simultaneous inputs.
module tb_view_ctrl;
  localparam logic [7:0] B_UP = 8'h01, B_DN = 8'h02, B_LT = 8'h04, B_RT = 8'h08;
  localparam logic [7:0] B_ZI = 8'h10, B_ZO = 8'h20, B_SEL = 8'h40, B_TOG = 8'h80;
  localparam int HOLD = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  btn = '0;
  logic        toggle_ready = 1'b0;
  logic [15:0] shift_x, shift_y;
  logic [3:0]  scroll;
  logic        setting_status, toggle_valid;
  logic [23:0] setting_pos, toggle_pos;
  int          tests = 0;
  int          fails = 0;

  view_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_zoom_in(btn[4]), .btn_zoom_out(btn[5]), .btn_select(btn[6]), .btn_toggle(btn[7]),
    .shift_x(shift_x), .shift_y(shift_y), .scroll(scroll),
    .setting_status(setting_status), .setting_pos(setting_pos),
    .toggle_valid(toggle_valid), .toggle_pos(toggle_pos), .toggle_ready(toggle_ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] m);
    btn = m;
    tick(HOLD);
    btn = '0;
    tick(HOLD);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
  endtask

  task automatic step(input logic [7:0] m);
    press(m);
    frame();
  endtask

  task automatic test_reset();
    tick(2);
    do_reset();
    tests++; if (shift_x !== 16'd0) begin fails++; $display("FAIL reset_shift_x got %0d want 0", shift_x); end
    tests++; if (shift_y !== 16'd0) begin fails++; $display("FAIL reset_shift_y got %0d want 0", shift_y); end
    tests++; if (scroll !== 4'd4) begin fails++; $display("FAIL reset_scroll got %0d want 4", scroll); end
    tests++; if (setting_status !== 1'b0) begin fails++; $display("FAIL reset_status got %0b want 0", setting_status); end
    tests++; if (setting_pos !== 24'd2) begin fails++; $display("FAIL reset_pos got %0d want 2", setting_pos); end
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %0b want 0", toggle_valid); end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? B_RT : 8'h00;
      tick(1);
    end
    btn = B_RT;
    tick(20);
    tests++; if (shift_x !== 16'd0) begin fails++; $display("FAIL deb_before_frame got %0d want 0", shift_x); end
    frame();
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL deb_move got %0d want 1", shift_x); end
    btn = '0;
    tick(25);
    frame();
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL deb_once got %0d want 1", shift_x); end
    btn = B_RT;
    tick(15);
    btn = '0;
    tick(25);
    frame();
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL deb_glitch15 got %0d want 1", shift_x); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 49; i++) step(B_RT);
    tests++; if (shift_x !== 16'd50) begin fails++; $display("FAIL clamp_reach50 got %0d want 50", shift_x); end
    step(B_RT);
    tests++; if (shift_x !== 16'd50) begin fails++; $display("FAIL clamp_max50 got %0d want 50", shift_x); end
    step(B_ZI);
    tests++; if (scroll !== 4'd5) begin fails++; $display("FAIL clamp_zin_scroll got %0d want 5", scroll); end
    tests++; if (shift_x !== 16'd50) begin fails++; $display("FAIL clamp_zin_shift got %0d want 50", shift_x); end
    step(B_ZI);
    tests++; if (scroll !== 4'd5) begin fails++; $display("FAIL clamp_zin_sat got %0d want 5", scroll); end
    step(B_ZO);
    step(B_ZO);
    tests++; if (scroll !== 4'd3) begin fails++; $display("FAIL clamp_zout_scroll got %0d want 3", scroll); end
    tests++; if (shift_x !== 16'd0) begin fails++; $display("FAIL clamp_zout_shift got %0d want 0", shift_x); end
    step(B_ZO);
    step(B_ZO);
    tests++; if (scroll !== 4'd2) begin fails++; $display("FAIL clamp_zmin_sat got %0d want 2", scroll); end
  endtask

  task automatic test_edit_follow();
    do_reset();
    step(B_SEL);
    tests++; if (setting_status !== 1'b1) begin fails++; $display("FAIL edit_enter got %0b want 1", setting_status); end
    for (int i = 0; i < 50; i++) step(B_RT);
    tests++; if (setting_pos !== 24'd52) begin fails++; $display("FAIL edit_pos52 got %0d want 52", setting_pos); end
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL edit_follow got %0d want 1", shift_x); end
    step(B_LT);
    tests++; if (setting_pos !== 24'd51) begin fails++; $display("FAIL edit_left got %0d want 51", setting_pos); end
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL edit_inside got %0d want 1", shift_x); end
  endtask

  task automatic test_handshake();
    do_reset();
    toggle_ready = 1'b0;
    step(B_SEL);
    for (int i = 0; i < 3; i++) step(B_RT);
    step(B_DN);
    step(B_DN);
    tests++; if (setting_pos !== 24'd205) begin fails++; $display("FAIL hs_pos205 got %0d want 205", setting_pos); end
    press(B_TOG);
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL hs_no_early_valid got %0b want 0", toggle_valid); end
    frame();
    tests++; if (toggle_valid !== 1'b1) begin fails++; $display("FAIL hs_valid_rise got %0b want 1", toggle_valid); end
    tests++; if (toggle_pos !== 24'd205) begin fails++; $display("FAIL hs_tpos got %0d want 205", toggle_pos); end
    tick(5);
    tests++; if (toggle_valid !== 1'b1) begin fails++; $display("FAIL hs_hold_valid got %0b want 1", toggle_valid); end
    step(B_SEL);
    tests++; if (setting_status !== 1'b1) begin fails++; $display("FAIL hs_sel_ignored got %0b want 1", setting_status); end
    step(B_RT);
    tests++; if (setting_pos !== 24'd206) begin fails++; $display("FAIL hs_move_in_wait got %0d want 206", setting_pos); end
    tests++; if (toggle_pos !== 24'd205) begin fails++; $display("FAIL hs_tpos_stable got %0d want 205", toggle_pos); end
    tests++; if (toggle_valid !== 1'b1) begin fails++; $display("FAIL hs_still_valid got %0b want 1", toggle_valid); end
    toggle_ready = 1'b1;
    tick(1);
    toggle_ready = 1'b0;
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL hs_drop got %0b want 0", toggle_valid); end
    toggle_ready = 1'b1;
    press(B_TOG);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tests++; if (toggle_valid !== 1'b1) begin fails++; $display("FAIL hs_back_in_edit got %0b want 1", toggle_valid); end
    tests++; if (toggle_pos !== 24'd206) begin fails++; $display("FAIL hs_tpos2 got %0d want 206", toggle_pos); end
    tick(1);
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL hs_one_cycle got %0b want 0", toggle_valid); end
    toggle_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(B_DN);
    tests++; if (shift_y !== 16'd1) begin fails++; $display("FAIL sim_down got %0d want 1", shift_y); end
    step(B_UP | B_DN | B_ZI | B_ZO);
    tests++; if (shift_y !== 16'd1) begin fails++; $display("FAIL sim_updown got %0d want 1", shift_y); end
    tests++; if (scroll !== 4'd4) begin fails++; $display("FAIL sim_zoom got %0d want 4", scroll); end
    step(B_UP);
    step(B_UP);
    tests++; if (shift_y !== 16'd0) begin fails++; $display("FAIL sim_up_at0 got %0d want 0", shift_y); end
    step(B_SEL);
    step(B_TOG);
    tests++; if (toggle_valid !== 1'b1) begin fails++; $display("FAIL sim_wait_valid got %0b want 1", toggle_valid); end
    do_reset();
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL sim_rst_valid got %0b want 0", toggle_valid); end
    tests++; if (setting_status !== 1'b0) begin fails++; $display("FAIL sim_rst_status got %0b want 0", setting_status); end
    step(B_TOG);
    tests++; if (toggle_valid !== 1'b0) begin fails++; $display("FAIL sim_browse_tog got %0b want 0", toggle_valid); end
    step(B_RT);
    tests++; if (shift_x !== 16'd1) begin fails++; $display("FAIL sim_browse_pan got %0d want 1", shift_x); end
    tests++; if (setting_pos !== 24'd2) begin fails++; $display("FAIL sim_browse_pos got %0d want 2", setting_pos); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clamp();
    test_edit_follow();
    test_handshake();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
